// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter (inhibit, request, frame, ack, timeout).
// Optional PS2_TX_RETRY_EN: one automatic retry of the latched byte after a nack or timeout.
module ps2_host_tx #(
  parameter int INHIBIT = 1056,
  parameter int TIMEOUT = 132000,
  parameter int FILTER  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ce,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_dat_oe,
  input  logic [7:0] i_d,
  input  logic       i_strobe,
  output logic       o_busy,
  output logic       o_rx_hold,
  output logic       o_done,
  output logic       o_error
);
  localparam int CW = $clog2((TIMEOUT > INHIBIT ? TIMEOUT : INHIBIT) + 1);
  localparam int FW = $clog2(FILTER + 1);

  typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_REQ, S_FRAME, S_ACK, S_WAITIDLE} state_t;

  state_t        r_state, w_state_nx;
  logic [1:0]    r_clk_s, r_dat_s;
  logic          r_clk_f;
  logic [FW-1:0] r_flt;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [3:0]    r_n, w_n_nx;
  logic [9:0]    r_sh, w_sh_nx;
  logic          r_clk_oe, w_clk_oe_nx, r_dat_oe, w_dat_oe_nx;
  logic          r_done, w_done_nx, r_error, w_error_nx, r_retry, w_retry_nx;
  logic          w_fall, w_tmo, w_fail, w_active;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_clk_s <= 2'b11;
      r_dat_s <= 2'b11;
      r_clk_f <= 1'b1;
      r_flt   <= '0;
    end else if (i_ce) begin
      r_clk_s <= {r_clk_s[0], i_ps2_clk};
      r_dat_s <= {r_dat_s[0], i_ps2_dat};
      if (r_clk_s[1] == r_clk_f)
        r_flt <= '0;
      else if (r_flt == FW'(FILTER - 1)) begin
        r_clk_f <= r_clk_s[1];
        r_flt   <= '0;
      end else
        r_flt <= r_flt + 1'b1;
    end

  // fall is the tick on which the filter accepts a 1->0 clock change
  assign w_fall   = r_clk_f && !r_clk_s[1] && (r_flt == FW'(FILTER - 1));
  assign w_tmo    = r_cnt >= CW'(TIMEOUT - 1);
  assign w_active = (r_state != S_IDLE) && (r_state != S_INHIBIT);

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    w_n_nx      = r_n;
    w_sh_nx     = r_sh;
    w_clk_oe_nx = r_clk_oe;
    w_dat_oe_nx = r_dat_oe;
    w_done_nx   = 1'b0;
    w_error_nx  = 1'b0;
    w_retry_nx  = r_retry;
    w_fail      = 1'b0;
    case (r_state)
      S_IDLE:
        if (i_strobe) begin
          w_sh_nx     = {1'b1, ~^i_d, i_d};
          w_retry_nx  = 1'b0;
          w_cnt_nx    = '0;
          w_clk_oe_nx = 1'b1;
          w_state_nx  = S_INHIBIT;
        end
      S_INHIBIT:
        if (r_cnt == CW'(INHIBIT - 1)) begin
          w_dat_oe_nx = 1'b1;
          w_cnt_nx    = '0;
          w_state_nx  = S_REQ;
        end
      S_REQ: begin
        w_clk_oe_nx = 1'b0;
        w_n_nx      = '0;
        w_state_nx  = S_FRAME;
      end
      S_FRAME:
        if (w_fall) begin
          w_n_nx      = r_n + 4'd1;
          w_dat_oe_nx = ~r_sh[r_n];
          w_state_nx  = (r_n == 4'd9) ? S_ACK : S_FRAME;
        end
      S_ACK:
        if (w_fall) begin
          w_fail     = r_dat_s[1];
          w_state_nx = S_WAITIDLE;
        end
      S_WAITIDLE:
        if (r_clk_f && r_dat_s[1]) begin
          w_done_nx  = 1'b1;
          w_state_nx = S_IDLE;
        end
      default: w_state_nx = S_IDLE;
    endcase
    if (w_active && w_fall)
      w_cnt_nx = '0;
    if (w_active && w_tmo && !w_fall && !w_done_nx)
      w_fail = 1'b1;
    if (w_fail) begin
      w_clk_oe_nx = 1'b0;
      w_dat_oe_nx = 1'b0;
      w_error_nx  = 1'b1;
      w_state_nx  = S_IDLE;
`ifdef PS2_TX_RETRY_EN
      if (!r_retry) begin
        w_error_nx  = 1'b0;
        w_retry_nx  = 1'b1;
        w_clk_oe_nx = 1'b1;
        w_cnt_nx    = '0;
        w_state_nx  = S_INHIBIT;
      end
`else
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_n      <= '0;
      r_sh     <= '0;
      r_clk_oe <= 1'b0;
      r_dat_oe <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_retry  <= 1'b0;
    end else if (i_ce) begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_n      <= w_n_nx;
      r_sh     <= w_sh_nx;
      r_clk_oe <= w_clk_oe_nx;
      r_dat_oe <= w_dat_oe_nx;
      r_done   <= w_done_nx;
      r_error  <= w_error_nx;
      r_retry  <= w_retry_nx;
    end

  assign o_ps2_clk_oe = r_clk_oe;
  assign o_ps2_dat_oe = r_dat_oe;
  assign o_busy       = r_state != S_IDLE;
  assign o_rx_hold    = o_busy;
  assign o_done       = r_done;
  assign o_error      = r_error;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a PS/2 device model; expected frame bits queued per byte sent.
module tb_ps2_host_tx;
  localparam int INH = 1056, TMO = 3000, FLT = 4, HALF = 40;

  logic clk = 1'b0, rst_n = 1'b0, ce = 1'b0, strobe = 1'b0, dev_clk = 1'b1, dev_dat = 1'b1;
  logic [7:0] d = 8'h00;
  logic clk_oe, dat_oe, busy, rx_hold, done, error;
  logic ps2_clk, ps2_dat;

  int checks = 0, errors = 0;
  int ce_div = 1, cyc = 0, inh_cnt = 0, done_cnt = 0, err_cnt = 0, inh_starts = 0;
  logic done_q = 1'b0, err_q = 1'b0, clk_oe_q = 1'b0, coincide = 1'b0;
  bit exp_q[$];

  assign ps2_clk = dev_clk & ~clk_oe;
  assign ps2_dat = dev_dat & ~dat_oe;

  ps2_host_tx #(.INHIBIT(INH), .TIMEOUT(TMO), .FILTER(FLT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_ps2_clk(ps2_clk), .i_ps2_dat(ps2_dat),
    .o_ps2_clk_oe(clk_oe), .o_ps2_dat_oe(dat_oe), .i_d(d), .i_strobe(strobe),
    .o_busy(busy), .o_rx_hold(rx_hold), .o_done(done), .o_error(error));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    ce = (cyc % ce_div) == 0;
    if (ce && clk_oe && !dat_oe) inh_cnt++;
    if (done && !done_q) done_cnt++;
    if (error && !err_q) err_cnt++;
    if (clk_oe && !clk_oe_q) inh_starts++;
    if (done && error) coincide = 1'b1;
    done_q = done;
    err_q = error;
    clk_oe_q = clk_oe;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] b);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    exp_q.push_back(($countones(b) % 2) == 0);
    exp_q.push_back(1'b1);
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    push_frame(b);
    d = b;
    strobe = 1'b1;
    while (!busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    strobe = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_rx_hold", rx_hold, 1);
  endtask

  task automatic wait_req();
    int t = 0;
    while (!(dat_oe && !clk_oe) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("request_seen", dat_oe && !clk_oe, 1);
  endtask

  task automatic dev_frame(input bit ack, input int glitch_at, input int stop_after);
    bit b;
    wait_req();
    for (int k = 1; k <= 11; k++) begin
      repeat (HALF) @(negedge clk);
      if (k == glitch_at) begin
        dev_clk = 1'b0;
        @(negedge clk);
        dev_clk = 1'b1;
        d = 8'hA5;
        strobe = 1'b1;
        repeat (3) @(negedge clk);
        strobe = 1'b0;
        repeat (HALF) @(negedge clk);
      end
      if (k == 11 && ack) dev_dat = 1'b0;
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (k <= 10) begin
        if (exp_q.size() == 0) chk($sformatf("bit%0d_queue", k), 0, 1);
        else begin
          b = exp_q.pop_front();
          chk($sformatf("bit%0d", k), !dat_oe, b);
        end
      end
      dev_clk = 1'b1;
      if (k == 11) begin
        repeat (HALF) @(negedge clk);
        dev_dat = 1'b1;
      end
      if (k == stop_after) return;
    end
  endtask

  initial begin
    int d0, e0, i0, c0, t;
    // reset state
    repeat (4) @(negedge clk);
    chk("rst_clk_oe", clk_oe, 0);
    chk("rst_dat_oe", dat_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rx_hold", rx_hold, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // 1: 0xED acked
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED);
    dev_frame(1'b1, 0, 0);
    repeat (20) @(negedge clk);
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_error", err_cnt - e0, 0);
    chk("t1_busy", busy, 0);
    chk("t1_dat_oe", dat_oe, 0);

    // 2: 0x07, parity 0, inhibit length at half-rate ce
    ce_div = 2;
    inh_cnt = 0;
    d0 = done_cnt;
    send(8'h07);
    dev_frame(1'b1, 0, 0);
    repeat (30) @(negedge clk);
    chk("t2_inhibit_ticks", inh_cnt, INH);
    chk("t2_done", done_cnt - d0, 1);
    ce_div = 1;

    // 3: device never clocks
    exp_q.delete();
    e0 = err_cnt; d0 = done_cnt; i0 = inh_starts;
    send(8'h55);
    exp_q.delete();
    wait_req();
    c0 = cyc;
    t = 0;
    while (err_cnt == e0 && t < 2 * (INH + TMO) + 500) begin
      @(negedge clk);
      t++;
    end
    chk("t3_error", err_cnt - e0, 1);
`ifndef PS2_TX_RETRY_EN
    chk("t3_timeout_window", (cyc - c0 >= TMO - 3) && (cyc - c0 <= TMO + 3), 1);
    chk("t3_inhibits", inh_starts - i0, 1);
`else
    chk("t3_inhibits", inh_starts - i0, 2);
`endif
    chk("t3_clk_oe", clk_oe, 0);
    chk("t3_dat_oe", dat_oe, 0);
    chk("t3_busy", busy, 0);
    chk("t3_done", done_cnt - d0, 0);

    // 4: nack
    e0 = err_cnt; d0 = done_cnt;
    send(8'h3C);
    dev_frame(1'b0, 0, 0);
`ifdef PS2_TX_RETRY_EN
    chk("t4_retry_busy", busy, 1);
    push_frame(8'h3C);
    dev_frame(1'b0, 0, 0);
`endif
    repeat (20) @(negedge clk);
    chk("t4_error", err_cnt - e0, 1);
    chk("t4_done", done_cnt - d0, 0);
    chk("t4_busy", busy, 0);

    // 5: reset mid-frame
    send(8'h5A);
    dev_frame(1'b1, 0, 5);
    rst_n = 1'b0;
    #1;
    chk("t5_clk_oe", clk_oe, 0);
    chk("t5_dat_oe", dat_oe, 0);
    chk("t5_busy", busy, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (10) @(negedge clk);
    d0 = done_cnt;
    send(8'h81);
    dev_frame(1'b1, 0, 0);
    repeat (20) @(negedge clk);
    chk("t5_done", done_cnt - d0, 1);

    // 6: clock glitch and strobe while busy
    d0 = done_cnt; e0 = err_cnt;
    send(8'h96);
    dev_frame(1'b1, 4, 0);
    repeat (20) @(negedge clk);
    chk("t6_done", done_cnt - d0, 1);
    i0 = inh_starts;
    repeat (INH + 200) @(negedge clk);
    chk("t6_no_second", inh_starts - i0, 0);
    chk("t6_busy", busy, 0);
    chk("t6_error", err_cnt - e0, 0);

    chk("done_error_coincide", coincide, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
